step_clk_ctrl: RTL and testbench

STEP_CLK_CTRL -- requirements
Module: step_clk_ctrl

---
 rtl/cpu_clk_pkg.sv | 15 +
 rtl/key_debounce.sv | 41 ++++
 rtl/step_clk_ctrl.sv | 122 ++++++++++++
 tb/tb_step_clk_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the stepping clock controller: FSM states and run-mode constants.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    FREE     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_FREE  = 2'b10;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for a raw push-button.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       r_key_db;

  assign key_db = r_key_db;

  // The counter only runs while the synchronized key disagrees with key_db;
  // any agreeing sample restarts the qualification window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= 2'b00;
      r_cnt    <= 8'd0;
      r_key_db <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], key_in};
      if (r_sync[1] != r_key_db) begin
        if (r_cnt == CNT_LAST) begin
          r_key_db <= r_sync[1];
          r_cnt    <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/step_clk_ctrl.sv
// CPU clock-enable controller: single step, burst and free-run actions launched by a
// debounced key press. All outputs are registered from the next-state logic.
module step_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             halt,
  output logic             cpu_ce,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_left,
  output state_t           o_dbg_state
);

  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

  logic           w_key_db;
  logic           w_trig;
  logic           r_key_db_q;
  state_t         r_state;
  state_t         w_state_nxt;
  logic [CNT_W:0] r_cnt;
  logic [CNT_W:0] w_cnt_nxt;
  logic           w_done_nxt;
  logic           w_active_nxt;
  logic           r_cpu_ce;
  logic           r_busy;
  logic           r_done;
  logic [CNT_W-1:0] r_cycles_left;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_in (key),
    .key_db (w_key_db)
  );

  assign w_trig = w_key_db & ~r_key_db_q;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig && !halt) begin
          case (mode)
            MODE_BURST: begin
              w_state_nxt = RUN;
              w_cnt_nxt   = (burst_len == '0) ? CNT_FULL : {1'b0, burst_len};
            end
            MODE_FREE: w_state_nxt = FREE;
            default: begin
              w_state_nxt = RUN;
              w_cnt_nxt   = CNT_ONE;
            end
          endcase
        end
      end
      RUN: begin
        // halt wins over the final cycle, so an aborted last cycle gives no done
        if (halt) begin
          w_state_nxt = WAIT_REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = WAIT_REL;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      FREE: begin
        if (halt || w_trig) w_state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!w_key_db) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_active_nxt = (w_state_nxt == RUN) || (w_state_nxt == FREE);

  // A full 2^CNT_W burst shows cycles_left = 0 on its first cycle (counter is one bit wider).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_key_db_q    <= 1'b0;
      r_cpu_ce      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cycles_left <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_key_db_q    <= w_key_db;
      r_cpu_ce      <= w_active_nxt;
      r_busy        <= w_active_nxt;
      r_done        <= w_done_nxt;
      r_cycles_left <= (w_state_nxt == RUN) ? w_cnt_nxt[CNT_W-1:0] : '0;
    end
  end

  assign cpu_ce      = r_cpu_ce;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cycles_left = r_cycles_left;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Bench for step_clk_ctrl: table of single/burst actions plus hand-written corner sequences.
module tb_step_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int CNT_W = 5;
  localparam int LAT   = 7;

  logic             clk;
  logic             rst;
  logic             key;
  logic [1:0]       mode;
  logic [CNT_W-1:0] burst_len;
  logic             halt;
  logic             cpu_ce;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles_left;
  state_t           o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]       mode;
    logic [CNT_W-1:0] blen;
    int               exp_n;
  } vec_t;

  vec_t vecs[6];

  step_clk_ctrl #(
    .DEB_CYCLES(4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .mode        (mode),
    .burst_len   (burst_len),
    .halt        (halt),
    .cpu_ce      (cpu_ce),
    .busy        (busy),
    .done        (done),
    .cycles_left (cycles_left),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ce(output int lat);
    lat = 0;
    while (!cpu_ce && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_key();
    key = 1'b0;
    repeat (10) tick();
    chk("back_to_idle", o_dbg_state, IDLE);
  endtask

  // driver + scoreboard for one table entry
  task automatic run_vec(input vec_t v);
    int lat;
    int cnt;
    int extra;
    logic [CNT_W-1:0] e;
    mode      = v.mode;
    burst_len = v.blen;
    for (int n = v.exp_n; n >= 1; n--) exp_q.push_back(CNT_W'(n));
    key = 1'b1;
    wait_ce(lat);
    chk("press_latency", lat, LAT);
    cnt = 0;
    while (cpu_ce && cnt < 40) begin
      cnt++;
      chk("sb_has_entry", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycles_left", cycles_left, e);
      end
      chk("busy_in_run", busy, 1);
      if (cnt == 1) begin
        mode      = MODE_FREE;
        burst_len = CNT_W'($urandom_range(1, 31));
      end
      tick();
    end
    chk("ce_count", cnt, v.exp_n);
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("cycles_left_after", cycles_left, 0);
    chk("state_wait_rel", o_dbg_state, WAIT_REL);
    tick();
    chk("done_single", done, 0);
    extra = 0;
    repeat (6) begin
      tick();
      extra += int'(cpu_ce);
    end
    chk("held_key_no_action", extra, 0);
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    release_key();
  endtask

  initial begin
    int lat;
    int cnt;
    int hits;

    vecs[0] = '{mode: 2'b00, blen: 5'd9,  exp_n: 1};
    vecs[1] = '{mode: 2'b11, blen: 5'd7,  exp_n: 1};
    vecs[2] = '{mode: 2'b01, blen: 5'd16, exp_n: 16};
    vecs[3] = '{mode: 2'b01, blen: 5'd0,  exp_n: 32};
    vecs[4] = '{mode: 2'b01, blen: 5'd1,  exp_n: 1};
    vecs[5] = '{mode: 2'b01, blen: 5'd3,  exp_n: 3};

    rst = 1'b1; key = 1'b0; mode = 2'b00; burst_len = '0; halt = 1'b0;
    repeat (3) tick();
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles_left", cycles_left, 0);
    chk("rst_state", o_dbg_state, IDLE);
    rst = 1'b0;
    repeat (3) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // bounce: toggle every 2 cycles, then steady high -> exactly one step
    mode = MODE_STEP;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      key = ((i / 2) % 2 == 0);
      tick();
      hits += int'(cpu_ce);
    end
    chk("bounce_no_trig", hits, 0);
    key = 1'b1;
    hits = 0;
    repeat (30) begin
      tick();
      hits += int'(cpu_ce);
    end
    chk("bounce_one_action", hits, 1);
    release_key();

    // free run: second press stops it one edge after its trig
    mode = MODE_FREE;
    key = 1'b1;
    wait_ce(lat);
    chk("free_latency", lat, LAT);
    key = 1'b0;
    hits = 0;
    repeat (15) begin
      tick();
      hits += int'(cpu_ce);
    end
    chk("free_stays_on", hits, 15);
    key = 1'b1;
    repeat (LAT - 1) tick();
    chk("free_on_before_trig", cpu_ce, 1);
    tick();
    chk("free_off", cpu_ce, 0);
    chk("free_busy_off", busy, 0);
    chk("free_no_done", done, 0);
    tick();
    chk("free_no_done_late", done, 0);
    release_key();

    // halt at cycle 5 of a 16-cycle burst
    mode = MODE_BURST; burst_len = 5'd16;
    key = 1'b1;
    wait_ce(lat);
    chk("abort_latency", lat, LAT);
    repeat (4) tick();
    chk("abort_cycle5_left", cycles_left, 12);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("abort_ce_off", cpu_ce, 0);
    chk("abort_busy_off", busy, 0);
    chk("abort_left_zero", cycles_left, 0);
    chk("abort_no_done", done, 0);
    tick();
    chk("abort_no_done_late", done, 0);
    release_key();

    // halt on the final burst cycle
    burst_len = 5'd3;
    key = 1'b1;
    wait_ce(lat);
    repeat (2) tick();
    chk("last_cycle_left", cycles_left, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("last_halt_ce_off", cpu_ce, 0);
    chk("last_halt_no_done", done, 0);
    tick();
    chk("last_halt_no_done_late", done, 0);
    release_key();

    // halt held in IDLE masks the trig
    halt = 1'b1;
    key = 1'b1;
    hits = 0;
    repeat (12) begin
      tick();
      hits += int'(cpu_ce);
    end
    chk("idle_halt_ignores_trig", hits, 0);
    key = 1'b0;
    repeat (10) tick();
    halt = 1'b0;
    chk("idle_halt_state", o_dbg_state, IDLE);

    // reset between edges in the middle of a burst, key kept high
    burst_len = 5'd16;
    key = 1'b1;
    wait_ce(lat);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ce", cpu_ce, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_left", cycles_left, 0);
    tick();
    rst = 1'b0;
    wait_ce(lat);
    chk("post_rst_latency", lat, LAT);
    cnt = 0;
    while (cpu_ce && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("post_rst_burst_len", cnt, 16);
    release_key();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
